// File: rtl/addr_sweep_gen_if.sv
// Control, configuration and status bundle for addr_sweep_gen.
// The master side issues commands and config; the slave side is the generator.
interface addr_sweep_gen_if #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4,
  parameter int WCNT_W = 8
);
  logic              start;
  logic              stop;
  logic              enable;
  logic              load_en;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  base;
  logic [WIDTH-1:0]  limit;
  logic [STEP_W-1:0] step;
  logic              dir;
  logic              mode;
  logic [WIDTH-1:0]  addr_out;
  logic              busy;
  logic              done;
  logic              wrap;
  logic [WCNT_W-1:0] wrap_cnt;
  logic              cfg_err;

  modport master (
    output start, stop, enable, load_en, load_val, base, limit, step, dir, mode,
    input  addr_out, busy, done, wrap, wrap_cnt, cfg_err
  );

  modport slave (
    input  start, stop, enable, load_en, load_val, base, limit, step, dir, mode,
    output addr_out, busy, done, wrap, wrap_cnt, cfg_err
  );
endinterface

// File: rtl/addr_sweep_gen.sv
// Address sweep generator: registered walk between base and limit with
// programmable step, direction and one-shot/wrap behaviour.
module addr_sweep_gen #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 4,
  parameter int WCNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  addr_sweep_gen_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_n;
  logic [WIDTH-1:0]  addr_q, addr_n;
  logic [WIDTH-1:0]  base_q, base_n;
  logic [WIDTH-1:0]  limit_q, limit_n;
  logic [STEP_W-1:0] step_q, step_n;
  logic              dir_q, dir_n;
  logic              mode_q, mode_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              wrap_q, wrap_n;
  logic [WCNT_W-1:0] wcnt_q, wcnt_n;
  logic              err_q, err_n;

  // One extra bit so the up/down terminal tests cannot overflow at the top of the address space
  logic [WIDTH:0]    step_x;
  logic [WIDTH:0]    up_nxt;
  logic              up_term;
  logic              down_term;

  assign step_x    = (WIDTH+1)'(step_q);
  assign up_nxt    = {1'b0, addr_q} + step_x;
  assign up_term   = up_nxt > {1'b0, limit_q};
  assign down_term = {1'b0, addr_q} < ({1'b0, base_q} + step_x);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      limit_q <= '0;
      step_q  <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
      base_q  <= base_n;
      limit_q <= limit_n;
      step_q  <= step_n;
      dir_q   <= dir_n;
      mode_q  <= mode_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      wrap_q  <= wrap_n;
      wcnt_q  <= wcnt_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    base_n  = base_q;
    limit_n = limit_q;
    step_n  = step_q;
    dir_n   = dir_q;
    mode_n  = mode_q;
    done_n  = 1'b0;
    wrap_n  = 1'b0;
    wcnt_n  = wcnt_q;
    err_n   = err_q;

    if (bus.stop) begin
      state_n = IDLE;
    end else if (bus.start) begin
      if (bus.base > bus.limit) begin
        err_n = 1'b1;
      end else begin
        base_n  = bus.base;
        limit_n = bus.limit;
        step_n  = (bus.step == '0) ? STEP_W'(1) : bus.step;
        dir_n   = bus.dir;
        mode_n  = bus.mode;
        addr_n  = bus.dir ? bus.limit : bus.base;
        wcnt_n  = '0;
        err_n   = 1'b0;
        state_n = RUN;
      end
    end else if (bus.load_en) begin
      if (state_q == RUN) begin
        if (bus.load_val < base_q)       addr_n = base_q;
        else if (bus.load_val > limit_q) addr_n = limit_q;
        else                             addr_n = bus.load_val;
      end else begin
        addr_n = bus.load_val;
      end
    end else if (bus.enable && state_q == RUN) begin
      if ((dir_q && !down_term) || (!dir_q && !up_term)) begin
        addr_n = dir_q ? (addr_q - WIDTH'(step_q)) : up_nxt[WIDTH-1:0];
      end else if (!mode_q) begin
        done_n  = 1'b1;
        state_n = DONE;
      end else begin
        addr_n = dir_q ? limit_q : base_q;
        wrap_n = 1'b1;
        if (wcnt_q != '1) wcnt_n = wcnt_q + WCNT_W'(1);
      end
    end

    busy_n = (state_n == RUN);
  end

  assign bus.addr_out = addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.wrap     = wrap_q;
  assign bus.wrap_cnt = wcnt_q;
  assign bus.cfg_err  = err_q;

endmodule

// File: doc/addr_sweep_gen.md
# addr_sweep_gen

Parametrised address sweep generator; next generation of the plain enable/clear address counter. It produces a registered address sequence between a programmable base and limit, with a programmable step, up/down direction, and one-shot or wrap-around mode. Start/stop control, terminal-count, wrap and error flags are included. It drives table index sweeps (predictor table init/clear, scrub and dump walks) from one clock domain.

## Interface
- WIDTH, 16, address width in bits (≥2)
- STEP_W, 4, width of the step input (step range 1..2^STEP_W-1)
- WCNT_W, 8, width of the saturating wrap counter

- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high; clears all state on the clk edge where it is sampled high
- start  in  1  one-cycle request: sample config, begin sweep
- stop  in  1  abort sweep; return to IDLE
- enable  in  1  advance one step this cycle (RUN only)
- load_en  in  1  overwrite current address with load_val
- load_val  in  WIDTH  load value
- base  in  WIDTH  lowest address of sweep window (sampled at start)
- limit  in  WIDTH  highest address of sweep window (sampled at start)
- step  in  STEP_W  increment magnitude (sampled at start; 0 treated as 1)
- dir  in  1  0 = up (base→limit), 1 = down (limit→base) (sampled at start)
- mode  in  1  0 = one-shot, 1 = wrap (sampled at start)
- addr_out  out  WIDTH  current address, registered
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on one-shot completion
- wrap  out  1  one-cycle pulse when wrap mode returns to the start address
- wrap_cnt  out  WCNT_W  wraps since last start, saturating at all-ones
- cfg_err  out  1  sticky: last start was rejected

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; addr_out, busy, done, wrap, wrap_cnt, cfg_err and all config registers are 0.
- Priority per cycle: reset > stop > start > load_en > enable.
- start in any state: if base > limit, reject it. State is unchanged, cfg_err=1, and addr_out is unchanged. Otherwise latch base_r, limit_r, step_r (0→1), dir_r and mode_r, then:
  - addr_out ← (dir ? limit : base)
  - wrap_cnt ← 0, cfg_err ← 0
  - state ← RUN
- stop: state ← IDLE; addr_out holds. No done pulse.
- load_en in RUN: addr_out ← load_val clamped to [base_r, limit_r]. In IDLE/DONE: addr_out ← load_val unclamped. No advance that cycle.
- enable in RUN, up: nxt = addr_out + step_r, computed in WIDTH+1 bits.
  - nxt ≤ limit_r: addr_out ← nxt.
  - Otherwise the sweep is terminal.
- enable in RUN, down: terminal when addr_out < base_r + step_r (WIDTH+1-bit compare); otherwise addr_out ← addr_out − step_r.
- Terminal, one-shot: addr_out holds the last in-range address, done=1 for one cycle, state ← DONE.
- Terminal, wrap: addr_out ← start address (base_r up / limit_r down), wrap=1 for one cycle, wrap_cnt +1 saturating; remain in RUN.
- Intermediate steps never leave the window; the last address is not necessarily equal to the limit when step > 1.
- base_r == limit_r: every enable is terminal.
- enable in IDLE/DONE: ignored.
- DONE behaves like IDLE except for state encoding; a start from DONE restarts the sweep.

## Timing
- All outputs registered; zero combinational input→output paths.
- start at edge N: addr_out = start address and busy=1 after edge N. The first advance is possible with enable sampled at edge N+1.
- One address per enabled cycle; full up-sweep, step 1, one-shot: (limit−base) enabled cycles to the last address. The next enabled cycle produces done.
- done and wrap assert in the cycle after the terminal enable edge and last exactly one cycle. busy drops in the same cycle as done.
- stop or reset mid-sweep takes effect at that edge; a pending terminal event in the same cycle is discarded.
- start with enable in the same cycle: start wins, no advance.

## Test plan
- Reset, then up one-shot, base=0x0010, limit=0x0014, step=1, enable held → addr_out 0x10,0x11,0x12,0x13,0x14. On the next cycle done=1 with addr 0x14, busy=0.
- Down wrap, base=0x0000, limit=0x0007, step=3, enable held → 7,4,1,7(wrap=1, wrap_cnt=1),4,1,7(wrap_cnt=2).
- WIDTH=16, up, base=0xFFF0, limit=0xFFFF, step=15, one-shot → 0xFFF0, 0xFFFF, then done. No overflow to 0x000E.
- start with base=0x20, limit=0x10 → cfg_err=1, state/addr unchanged. A valid start then clears cfg_err.
- Mid-sweep load_val=0x0500 with window 0x10..0x1F → addr_out=0x001F. Next enable in up one-shot → done.
- stop during RUN at addr 0x12 → busy=0, addr 0x12 held, no done. Reset asserted with enable → all outputs 0 on the next edge.
